pipe_stage_skid: RTL and testbench

//  Parametrised pipeline stage register, the successor to the fixed ID/EXE latch.

---
 rtl/pipe_pkg.sv | 37 +++
 rtl/pipe_sat_counter.sv | 23 ++
 rtl/pipe_stage_skid.sv | 124 ++++++++++++
 tb/tb_pipe_stage_skid.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared widths, bundle field positions and occupancy encoding for pipeline stage registers.
// Field localparams give the LSB of each field so stage wrappers can pack/unpack the buses.
package pipe_pkg;

    localparam int unsigned ID_EXE_CTRL_W = 15;
    localparam int unsigned ID_EXE_DATA_W = 123;

    // Control bundle, packed MSB-first: sel_op at the top, reg_wrs at bit 0.
    localparam int unsigned SEL_OP   = 14;
    localparam int unsigned SEL_INT  = 13;
    localparam int unsigned SEL_VEC  = 11;
    localparam int unsigned OPCODE   = 7;
    localparam int unsigned SUM_MEM  = 6;
    localparam int unsigned SEL_MEM  = 5;
    localparam int unsigned SEL_DATA = 4;
    localparam int unsigned MEM_WR   = 3;
    localparam int unsigned SEL_WB   = 2;
    localparam int unsigned REG_WRV  = 1;
    localparam int unsigned REG_WRS  = 0;

    // Data bundle: three 32-bit vectors, three 8-bit scalars, 3-bit destination.
    localparam int unsigned VEC1      = 91;
    localparam int unsigned VEC2      = 59;
    localparam int unsigned VFS       = 27;
    localparam int unsigned SCA1      = 19;
    localparam int unsigned INMEDIATO = 11;
    localparam int unsigned SHIFT     = 3;
    localparam int unsigned DIR_DEST  = 0;

    // Encoding equals the number of beats held, so the state drives occupancy directly.
    typedef enum logic [1:0] {
        OccEmpty = 2'd0,
        OccOne   = 2'd1,
        OccFull  = 2'd2
    } occ_e;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter: increments when inc is high, sticks at all-ones.
module pipe_sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign cnt = r_cnt;

endmodule

// File: rtl/pipe_stage_skid.sv
// Ready/valid pipeline stage register with a 2-entry skid buffer, flush and stall counter.
// in_ready depends only on registered state, so no combinational path crosses the stage.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int unsigned CTRL_W    = ID_EXE_CTRL_W,
    parameter int unsigned DATA_W    = ID_EXE_DATA_W,
    parameter int unsigned ZERO_CTRL = 1,
    parameter int unsigned CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    occ_e              r_state;
    occ_e              w_state_d;
    logic [CTRL_W-1:0] r_main_ctrl;
    logic [DATA_W-1:0] r_main_data;
    logic [CTRL_W-1:0] r_skid_ctrl;
    logic [DATA_W-1:0] r_skid_data;

    logic w_main_valid;
    logic w_in_xfer;
    logic w_out_xfer;
    logic w_ld_main_in;
    logic w_ld_main_skid;
    logic w_ld_skid;

    assign w_main_valid = (r_state != OccEmpty);
    assign in_ready     = (r_state != OccFull);
    assign w_in_xfer    = in_valid & in_ready;
    assign w_out_xfer   = w_main_valid & out_ready;

    always_comb begin
        w_state_d      = r_state;
        w_ld_main_in   = 1'b0;
        w_ld_main_skid = 1'b0;
        w_ld_skid      = 1'b0;
        unique case (r_state)
            OccEmpty: begin
                if (w_in_xfer) begin
                    w_state_d    = OccOne;
                    w_ld_main_in = 1'b1;
                end
            end
            OccOne: begin
                if (w_in_xfer && w_out_xfer) begin
                    w_ld_main_in = 1'b1;
                end else if (w_in_xfer) begin
                    w_state_d = OccFull;
                    w_ld_skid = 1'b1;
                end else if (w_out_xfer) begin
                    w_state_d = OccEmpty;
                end
            end
            OccFull: begin
                if (w_out_xfer) begin
                    w_state_d      = OccOne;
                    w_ld_main_skid = 1'b1;
                end
            end
            default: w_state_d = OccEmpty;
        endcase
        // Flush drops every held or in-flight beat; data registers are left untouched.
        if (flush) begin
            w_state_d      = OccEmpty;
            w_ld_main_in   = 1'b0;
            w_ld_main_skid = 1'b0;
            w_ld_skid      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= OccEmpty;
            r_main_ctrl <= '0;
            r_main_data <= '0;
            r_skid_ctrl <= '0;
            r_skid_data <= '0;
        end else begin
            r_state <= w_state_d;
            if (flush) begin
                r_main_ctrl <= '0;
            end else if (w_ld_main_in) begin
                r_main_ctrl <= in_ctrl;
                r_main_data <= in_data;
            end else if (w_ld_main_skid) begin
                r_main_ctrl <= r_skid_ctrl;
                r_main_data <= r_skid_data;
            end
            if (w_ld_skid) begin
                r_skid_ctrl <= in_ctrl;
                r_skid_data <= in_data;
            end
        end
    end

    pipe_sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_main_valid & ~out_ready),
        .cnt   (stall_cnt)
    );

    assign out_valid = w_main_valid;
    assign out_data  = r_main_data;
    assign occupancy = r_state;
    // Bubbles present a zero control word so no write enable leaks downstream.
    assign out_ctrl  = ((ZERO_CTRL != 0) && !w_main_valid) ? '0 : r_main_ctrl;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: directed scenarios plus a random scoreboard run.
module tb_pipe_stage_skid;

    localparam int CW = 15;
    localparam int DW = 123;
    localparam int NW = 16;

    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_ready, flush, out_valid, out_ready;
    logic [CW-1:0] in_ctrl, out_ctrl;
    logic [DW-1:0] in_data, out_data;
    logic [1:0]    occupancy;
    logic [NW-1:0] stall_cnt;

    logic          s_in_valid, s_in_ready, s_flush, s_out_valid, s_out_ready;
    logic [CW-1:0] s_in_ctrl, s_out_ctrl;
    logic [DW-1:0] s_in_data, s_out_data;
    logic [1:0]    s_occupancy;
    logic [3:0]    s_stall_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipe_stage_skid #(
        .CTRL_W    (CW),
        .DATA_W    (DW),
        .ZERO_CTRL (1),
        .CNT_W     (NW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .occupancy (occupancy),
        .stall_cnt (stall_cnt)
    );

    pipe_stage_skid #(
        .CTRL_W    (CW),
        .DATA_W    (DW),
        .ZERO_CTRL (1),
        .CNT_W     (4)
    ) dut_s (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (s_in_valid),
        .in_ready  (s_in_ready),
        .in_ctrl   (s_in_ctrl),
        .in_data   (s_in_data),
        .flush     (s_flush),
        .out_valid (s_out_valid),
        .out_ready (s_out_ready),
        .out_ctrl  (s_out_ctrl),
        .out_data  (s_out_data),
        .occupancy (s_occupancy),
        .stall_cnt (s_stall_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        in_ctrl = '0; in_data = '0;
        step(); step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1; flush = 1'b0;
        in_ctrl = 15'h7FFF; in_data = 123'h5A5A;
        step(); step();
        total += 6;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b want=0", out_valid); end
        if (out_ctrl !== '0) begin bad++; $display("FAIL reset_out_ctrl got=%0h want=0", out_ctrl); end
        if (out_data !== '0) begin bad++; $display("FAIL reset_out_data got=%0h want=0", out_data); end
        if (occupancy !== 2'd0) begin bad++; $display("FAIL reset_occ got=%0d want=0", occupancy); end
        if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b want=1", in_ready); end
        if (stall_cnt !== '0) begin bad++; $display("FAIL reset_stall got=%0d want=0", stall_cnt); end
        in_valid = 1'b0;
        rst_n = 1'b1;
        step();
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_ignored got=%0b want=0", out_valid); end
    endtask

    task automatic test_streaming();
        beat_t q[$];
        beat_t e;
        do_reset();
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1; in_ctrl = CW'(i); in_data = DW'(i);
            q.push_back({CW'(i), DW'(i)});
            step();
            e = q.pop_front();
            total += 5;
            if (out_valid !== 1'b1) begin bad++; $display("FAIL stream_valid beat=%0d got=%0b want=1", i, out_valid); end
            if (out_data !== e.d) begin bad++; $display("FAIL stream_data got=%0h want=%0h", out_data, e.d); end
            if (out_ctrl !== e.c) begin bad++; $display("FAIL stream_ctrl got=%0h want=%0h", out_ctrl, e.c); end
            if (occupancy !== 2'd1) begin bad++; $display("FAIL stream_occ got=%0d want=1", occupancy); end
            if (in_ready !== 1'b1) begin bad++; $display("FAIL stream_in_ready got=%0b want=1", in_ready); end
        end
        in_valid = 1'b0;
        step();
        total += 3;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL stream_drain_valid got=%0b want=0", out_valid); end
        if (out_ctrl !== '0) begin bad++; $display("FAIL stream_bubble_ctrl got=%0h want=0", out_ctrl); end
        if (stall_cnt !== '0) begin bad++; $display("FAIL stream_stall got=%0d want=0", stall_cnt); end
    endtask

    task automatic test_skid();
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_ctrl = 15'h00A; in_data = 123'hA;
        step();
        in_ctrl = 15'h00B; in_data = 123'hB;
        step();
        total += 3;
        if (occupancy !== 2'd2) begin bad++; $display("FAIL skid_occ got=%0d want=2", occupancy); end
        if (in_ready !== 1'b0) begin bad++; $display("FAIL skid_in_ready got=%0b want=0", in_ready); end
        if (out_data !== 123'hA) begin bad++; $display("FAIL skid_head got=%0h want=a", out_data); end
        in_ctrl = 15'h00C; in_data = 123'hC;
        step(); step();
        total += 3;
        if (occupancy !== 2'd2) begin bad++; $display("FAIL skid_hold_occ got=%0d want=2", occupancy); end
        if (out_data !== 123'hA) begin bad++; $display("FAIL skid_hold_head got=%0h want=a", out_data); end
        if (stall_cnt !== 16'd3) begin bad++; $display("FAIL skid_stall got=%0d want=3", stall_cnt); end
        out_ready = 1'b1;
        step();
        total += 3;
        if (out_data !== 123'hB) begin bad++; $display("FAIL skid_second got=%0h want=b", out_data); end
        if (out_ctrl !== 15'h00B) begin bad++; $display("FAIL skid_second_ctrl got=%0h want=b", out_ctrl); end
        if (in_ready !== 1'b1) begin bad++; $display("FAIL skid_reopen got=%0b want=1", in_ready); end
        step();
        total += 2;
        if (out_data !== 123'hC) begin bad++; $display("FAIL skid_third got=%0h want=c", out_data); end
        if (occupancy !== 2'd1) begin bad++; $display("FAIL skid_third_occ got=%0d want=1", occupancy); end
        in_valid = 1'b0;
        step();
        total += 2;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL skid_drained got=%0b want=0", out_valid); end
        if (stall_cnt !== 16'd3) begin bad++; $display("FAIL skid_stall_final got=%0d want=3", stall_cnt); end
    endtask

    task automatic test_flush();
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_ctrl = 15'h001; in_data = 123'h11;
        step();
        in_ctrl = 15'h002; in_data = 123'h22;
        step();
        in_ctrl = 15'h7FFF; in_data = 123'h33; flush = 1'b1;
        step();
        flush = 1'b0;
        total += 5;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%0b want=0", out_valid); end
        if (out_ctrl !== '0) begin bad++; $display("FAIL flush_ctrl got=%0h want=0", out_ctrl); end
        if (occupancy !== 2'd0) begin bad++; $display("FAIL flush_occ got=%0d want=0", occupancy); end
        if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_in_ready got=%0b want=1", in_ready); end
        if (stall_cnt !== 16'd2) begin bad++; $display("FAIL flush_stall got=%0d want=2", stall_cnt); end
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_lost got=%0b want=0", out_valid); end
    endtask

    task automatic test_saturation();
        logic [3:0] e;
        s_in_valid = 1'b1; s_out_ready = 1'b0; s_flush = 1'b0;
        s_in_ctrl = 15'h1; s_in_data = 123'h1;
        step();
        s_in_valid = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            step();
            e = (i > 15) ? 4'd15 : 4'(i);
            total++;
            if (s_stall_cnt !== e) begin bad++; $display("FAIL sat_cnt cycle=%0d got=%0d want=%0d", i, s_stall_cnt, e); end
        end
    endtask

    task automatic test_scoreboard();
        beat_t        mq[$];
        logic [127:0] r;
        logic [NW-1:0] exp_stall;
        logic         ev;
        int           sz;
        do_reset();
        exp_stall = '0;
        for (int n = 0; n < 10000; n++) begin
            for (int k = 0; k < 4; k++) r[k*32 +: 32] = $urandom;
            in_data   = r[DW-1:0];
            in_ctrl   = CW'($urandom_range(0, 32767));
            in_valid  = ($urandom_range(0, 99) < 70);
            out_ready = ($urandom_range(0, 99) < 60);
            flush     = ($urandom_range(0, 99) < 5);
            sz = mq.size();
            ev = (sz > 0);
            total += 5;
            if (out_valid !== ev) begin bad++; $display("FAIL sb_valid n=%0d got=%0b want=%0b", n, out_valid, ev); end
            if (in_ready !== (sz < 2)) begin bad++; $display("FAIL sb_in_ready n=%0d got=%0b want=%0b", n, in_ready, sz < 2); end
            if (occupancy !== 2'(sz)) begin bad++; $display("FAIL sb_occ n=%0d got=%0d want=%0d", n, occupancy, sz); end
            if (stall_cnt !== exp_stall) begin bad++; $display("FAIL sb_stall n=%0d got=%0d want=%0d", n, stall_cnt, exp_stall); end
            if (ev) begin
                if (out_ctrl !== mq[0].c) begin bad++; $display("FAIL sb_ctrl n=%0d got=%0h want=%0h", n, out_ctrl, mq[0].c); end
                total++;
                if (out_data !== mq[0].d) begin bad++; $display("FAIL sb_data n=%0d got=%0h want=%0h", n, out_data, mq[0].d); end
            end else begin
                if (out_ctrl !== '0) begin bad++; $display("FAIL sb_bubble_ctrl n=%0d got=%0h want=0", n, out_ctrl); end
            end
            if (ev && !out_ready && exp_stall != '1) exp_stall = exp_stall + 1'b1;
            if (flush) begin
                mq.delete();
            end else begin
                if (ev && out_ready) void'(mq.pop_front());
                if (in_valid && sz < 2) mq.push_back({in_ctrl, in_data});
            end
            step();
        end
        in_valid = 1'b0; flush = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; in_ctrl = '0; in_data = '0;
        s_in_valid = 1'b0; s_flush = 1'b0; s_out_ready = 1'b0; s_in_ctrl = '0; s_in_data = '0;
        test_reset();
        test_streaming();
        test_skid();
        test_flush();
        test_saturation();
        test_scoreboard();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
